// File: rtl/lock_entry_controller_pkg.sv
// Shared types and constants for the combination-lock entry controller.
// Optional feature macro used by the controller: CODE_PROGRAM_EN.
package lock_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        SETTLE  = 2'd2,
        LOCKOUT = 2'd3
    } ctrlState_t;

    function automatic int maxLimit(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_entry_controller_if.sv
// Bundle between the button/switch front end, the lock FSM and the entry controller.
interface lock_entry_controller_if #(
    parameter int DIGIT_W = lock_pkg::DIGIT_W
);
    logic               btn_pulse;
    logic [DIGIT_W-1:0] digit_in;
    logic               prog;
    logic [1:0]         fsm_state;
    logic               enter_o;
    logic               correct_digit_o;
    logic               lockout_led;
    logic [1:0]         fail_count;
    logic               busy;

    modport master (
        output btn_pulse, digit_in, prog, fsm_state,
        input  enter_o, correct_digit_o, lockout_led, fail_count, busy
    );

    modport slave (
        input  btn_pulse, digit_in, prog, fsm_state,
        output enter_o, correct_digit_o, lockout_led, fail_count, busy
    );
endinterface

// File: rtl/lock_entry_controller_timer.sv
// Clearable up-counter with a terminal-count flag against a runtime limit.
module lock_timer #(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_done
);
    logic [WIDTH-1:0] r_count;

    // Clear has priority so a terminal count restarts from zero on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == i_limit);
endmodule

// File: rtl/lock_entry_controller.sv
// Turns debounced presses into enter/correct strobes for the lock FSM, with
// failed-attempt lockout and auto-relock. Optional macro: CODE_PROGRAM_EN.
module lock_entry_controller #(
    parameter int               DIGIT_W        = 4,
    parameter int               MAX_FAILS      = 3,
    parameter int               LOCKOUT_CYCLES = 50000000,
    parameter int               RELOCK_CYCLES  = 100000000,
    parameter logic [DIGIT_W-1:0] CODE0        = DIGIT_W'(3),
    parameter logic [DIGIT_W-1:0] CODE1        = DIGIT_W'(7),
    parameter logic [DIGIT_W-1:0] CODE2        = DIGIT_W'(1)
)(
    input logic               clk,
    input logic               reset,
    lock_entry_controller_if.slave bus
);
    import lock_pkg::*;

    localparam int TIMER_MAX = maxLimit(LOCKOUT_CYCLES, RELOCK_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam logic [TIMER_W-1:0] LOCK_LIMIT   = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RELOCK_LIMIT = TIMER_W'(RELOCK_CYCLES - 1);

    ctrlState_t         r_state;
    ctrlState_t         w_nextState;
    logic               r_correct;
    logic               r_isDigit;
    logic [1:0]         r_failCount;
    logic               w_pressCorrect;
    logic               w_pressDigit;
    logic               w_timerClear;
    logic               w_timerEnable;
    logic               w_timerDone;
    logic [TIMER_W-1:0] w_timerLimit;
    logic               w_unlocked;
    logic               w_progWrite;
    logic               w_relock;
    logic [DIGIT_W-1:0] w_code0;
    logic [DIGIT_W-1:0] w_code1;
    logic [DIGIT_W-1:0] w_code2;
    logic [DIGIT_W-1:0] w_codeSel;
    logic               w_cmp;

    assign w_unlocked   = (bus.fsm_state == S3);
    assign w_timerLimit = (r_state == LOCKOUT) ? LOCK_LIMIT : RELOCK_LIMIT;
    assign w_relock     = (r_state == IDLE) && (w_nextState == PULSE) && w_unlocked;

`ifdef CODE_PROGRAM_EN
    logic [DIGIT_W-1:0] r_code0;
    logic [DIGIT_W-1:0] r_code1;
    logic [DIGIT_W-1:0] r_code2;
    logic [1:0]         r_progIdx;

    assign w_progWrite = (r_state == IDLE) && w_unlocked && bus.prog && bus.btn_pulse;
    assign w_code0     = r_code0;
    assign w_code1     = r_code1;
    assign w_code2     = r_code2;

    // Programmable code store; the write pointer rewinds whenever the lock relocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code0   <= CODE0;
            r_code1   <= CODE1;
            r_code2   <= CODE2;
            r_progIdx <= 2'd0;
        end else if (w_progWrite) begin
            case (r_progIdx)
                2'd0:    r_code0 <= bus.digit_in;
                2'd1:    r_code1 <= bus.digit_in;
                default: r_code2 <= bus.digit_in;
            endcase
            r_progIdx <= (r_progIdx == 2'd2) ? 2'd0 : r_progIdx + 2'd1;
        end else if (w_relock) begin
            r_progIdx <= 2'd0;
        end
    end
`else
    logic w_unusedProg;

    assign w_unusedProg = bus.prog;
    assign w_progWrite  = 1'b0;
    assign w_code0      = CODE0;
    assign w_code1      = CODE1;
    assign w_code2      = CODE2;
`endif

    // Pick the code digit matching the lock FSM's live progress.
    always_comb begin
        w_codeSel = w_code0;
        case (bus.fsm_state)
            S1:      w_codeSel = w_code1;
            S2:      w_codeSel = w_code2;
            default: w_codeSel = w_code0;
        endcase
    end

    assign w_cmp = (bus.digit_in == w_codeSel);

    lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timerClear),
        .i_enable (w_timerEnable),
        .i_limit  (w_timerLimit),
        .o_done   (w_timerDone)
    );

    // Next-state and timer control; the timer only runs while unlocked-idle or in lockout.
    always_comb begin
        w_nextState    = r_state;
        w_timerClear   = 1'b1;
        w_timerEnable  = 1'b0;
        w_pressCorrect = 1'b0;
        w_pressDigit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_unlocked) begin
                    w_timerClear  = 1'b0;
                    w_timerEnable = 1'b1;
                    if (w_progWrite) begin
                        w_timerClear = 1'b1;
                    end else if (bus.btn_pulse || w_timerDone) begin
                        w_nextState  = PULSE;
                        w_timerClear = 1'b1;
                    end
                end else if (bus.btn_pulse) begin
                    w_nextState    = PULSE;
                    w_pressDigit   = 1'b1;
                    w_pressCorrect = w_cmp;
                end
            end
            PULSE: begin
                w_nextState = SETTLE;
            end
            SETTLE: begin
                w_nextState = (r_failCount == 2'(MAX_FAILS)) ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                w_timerClear  = 1'b0;
                w_timerEnable = 1'b1;
                if (w_timerDone) begin
                    w_nextState  = IDLE;
                    w_timerClear = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture the press result so it can be presented during PULSE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_correct <= 1'b0;
            r_isDigit <= 1'b0;
        end else if ((r_state == IDLE) && (w_nextState == PULSE)) begin
            r_correct <= w_pressCorrect;
            r_isDigit <= w_pressDigit;
        end
    end

    // Consecutive wrong-digit counter; relock pulses leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_failCount <= 2'd0;
        end else if ((r_state == PULSE) && r_isDigit) begin
            r_failCount <= r_correct ? 2'd0 : r_failCount + 2'd1;
        end else if ((r_state == LOCKOUT) && (w_nextState == IDLE)) begin
            r_failCount <= 2'd0;
        end
    end

    assign bus.enter_o         = (r_state == PULSE);
    assign bus.correct_digit_o = (r_state == PULSE) && r_correct;
    assign bus.lockout_led     = (r_state == LOCKOUT);
    assign bus.fail_count      = r_failCount;
    assign bus.busy            = (r_state != IDLE);
endmodule

// File: tb/tb_lock_entry_controller.sv
// Randomized self-checking bench for lock_entry_controller with a behavioural lock FSM.
module tb_lock_entry_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   code [3] = '{3, 7, 1};
    int   modelLevel = 0;
    int   modelFails = 0;

    lock_entry_controller_if #(.DIGIT_W(4)) bus();

    lock_entry_controller #(
        .DIGIT_W        (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (8),
        .RELOCK_CYCLES  (16),
        .CODE0          (4'd3),
        .CODE1          (4'd7),
        .CODE2          (4'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural lock FSM: a correct digit advances, anything else returns to 0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.fsm_state <= 2'd0;
        end else if (bus.enter_o) begin
            bus.fsm_state <= (bus.correct_digit_o && bus.fsm_state != 2'd3) ? bus.fsm_state + 2'd1 : 2'd0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        bus.btn_pulse = 1'b0;
        bus.digit_in = 4'd0;
        bus.prog = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        modelLevel = 0;
        modelFails = 0;
        tick();
    endtask

    task automatic pressDigit(input logic [3:0] d, input string tag);
        logic expCorrect;
        int   expFails;
        int   count;
        logic sawEnter;
        if (modelLevel == 3) begin
            expCorrect = 1'b0;
            expFails = modelFails;
        end else begin
            expCorrect = (int'(d) == code[modelLevel]);
            expFails = expCorrect ? 0 : modelFails + 1;
        end
        bus.digit_in = d;
        bus.btn_pulse = 1'b1;
        tick();
        bus.btn_pulse = 1'b0;
        checks++;
        if (bus.enter_o !== 1'b1) $display("[TB] FAIL %s enter_o got %b want 1", tag, bus.enter_o); else passes++;
        checks++;
        if (bus.correct_digit_o !== expCorrect) $display("[TB] FAIL %s correct got %b want %b", tag, bus.correct_digit_o, expCorrect); else passes++;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.enter_o !== 1'b0) $display("[TB] FAIL %s settle busy/enter got %b/%b want 1/0", tag, bus.busy, bus.enter_o); else passes++;
        checks++;
        if (bus.fail_count !== 2'(expFails)) $display("[TB] FAIL %s fail_count got %0d want %0d", tag, bus.fail_count, expFails); else passes++;
        modelLevel = expCorrect ? modelLevel + 1 : 0;
        modelFails = expFails;
        tick();
        checks++;
        if (bus.fsm_state !== 2'(modelLevel)) $display("[TB] FAIL %s fsm_state got %0d want %0d", tag, bus.fsm_state, modelLevel); else passes++;
        if (modelFails == 3) begin
            count = 0;
            sawEnter = 1'b0;
            while (bus.lockout_led === 1'b1 && count < 40) begin
                if (count == 3) begin
                    bus.digit_in = 4'd3;
                    bus.btn_pulse = 1'b1;
                end
                tick();
                bus.btn_pulse = 1'b0;
                if (bus.enter_o === 1'b1) sawEnter = 1'b1;
                count++;
            end
            tick();
            if (bus.enter_o === 1'b1) sawEnter = 1'b1;
            tick();
            if (bus.enter_o === 1'b1) sawEnter = 1'b1;
            checks++;
            if (count != 8) $display("[TB] FAIL %s lockout length got %0d want 8", tag, count); else passes++;
            checks++;
            if (sawEnter !== 1'b0) $display("[TB] FAIL %s press during lockout got enter want none", tag); else passes++;
            checks++;
            if (bus.fail_count !== 2'd0 || bus.lockout_led !== 1'b0) $display("[TB] FAIL %s post-lockout fail/led got %0d/%b want 0/0", tag, bus.fail_count, bus.lockout_led); else passes++;
            modelFails = 0;
        end
    endtask

    task automatic unlock(input string tag);
        for (int i = 0; i < 3; i++) begin
            pressDigit(4'(code[i]), tag);
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if ({bus.enter_o, bus.correct_digit_o, bus.lockout_led, bus.busy} !== 4'b0000) $display("[TB] FAIL reset outputs got %b want 0000", {bus.enter_o, bus.correct_digit_o, bus.lockout_led, bus.busy}); else passes++;
        checks++;
        if (bus.fail_count !== 2'd0) $display("[TB] FAIL reset fail_count got %0d want 0", bus.fail_count); else passes++;
        pressDigit(4'd5, "reset_pre");
        tick();
        bus.digit_in = 4'd3;
        bus.btn_pulse = 1'b1;
        tick();
        bus.btn_pulse = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.enter_o !== 1'b0 || bus.fail_count !== 2'd0) $display("[TB] FAIL midreset enter/fail got %b/%0d want 0/0", bus.enter_o, bus.fail_count); else passes++;
        tick();
        reset = 1'b0;
        modelLevel = 0;
        modelFails = 0;
        tick();
    endtask

    task automatic test_unlock();
        unlock("unlock");
        checks++;
        if (bus.fsm_state !== 2'd3 || bus.fail_count !== 2'd0) $display("[TB] FAIL unlock state/fail got %0d/%0d want 3/0", bus.fsm_state, bus.fail_count); else passes++;
        applyReset();
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 3; i++) begin
            pressDigit(4'd5, "lockout");
            tick();
        end
        applyReset();
    endtask

    task automatic test_auto_relock();
        int n;
        for (int i = 0; i < 3; i++) begin
            pressDigit(4'(code[i]), "relock_unlock");
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.enter_o !== 1'b1 && n < 40);
        checks++;
        if (n != 16) $display("[TB] FAIL auto_relock latency got %0d want 16", n); else passes++;
        checks++;
        if (bus.correct_digit_o !== 1'b0) $display("[TB] FAIL auto_relock correct got %b want 0", bus.correct_digit_o); else passes++;
        tick();
        tick();
        modelLevel = 0;
        checks++;
        if (bus.fsm_state !== 2'd0) $display("[TB] FAIL auto_relock fsm_state got %0d want 0", bus.fsm_state); else passes++;
    endtask

    task automatic test_relock_collision();
        int pulses;
        for (int i = 0; i < 3; i++) begin
            pressDigit(4'(code[i]), "collide_unlock");
        end
        for (int i = 0; i < 15; i++) tick();
        bus.digit_in = 4'd3;
        bus.btn_pulse = 1'b1;
        tick();
        bus.btn_pulse = 1'b0;
        checks++;
        if (bus.enter_o !== 1'b1 || bus.correct_digit_o !== 1'b0) $display("[TB] FAIL collision pulse enter/correct got %b/%b want 1/0", bus.enter_o, bus.correct_digit_o); else passes++;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.enter_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL collision extra pulses got %0d want 0", pulses); else passes++;
        modelLevel = 0;
        checks++;
        if (bus.fsm_state !== 2'd0) $display("[TB] FAIL collision fsm_state got %0d want 0", bus.fsm_state); else passes++;
    endtask

    task automatic test_back_to_back();
        bus.digit_in = 4'd3;
        bus.btn_pulse = 1'b1;
        tick();
        checks++;
        if (bus.enter_o !== 1'b1 || bus.busy !== 1'b1) $display("[TB] FAIL b2b first enter/busy got %b/%b want 1/1", bus.enter_o, bus.busy); else passes++;
        tick();
        bus.btn_pulse = 1'b0;
        checks++;
        if (bus.enter_o !== 1'b0 || bus.busy !== 1'b1) $display("[TB] FAIL b2b settle enter/busy got %b/%b want 0/1", bus.enter_o, bus.busy); else passes++;
        tick();
        checks++;
        if (bus.enter_o !== 1'b0 || bus.busy !== 1'b0) $display("[TB] FAIL b2b idle enter/busy got %b/%b want 0/0", bus.enter_o, bus.busy); else passes++;
        modelLevel = 1;
        checks++;
        if (bus.fsm_state !== 2'd1) $display("[TB] FAIL b2b fsm_state got %0d want 1", bus.fsm_state); else passes++;
        pressDigit(4'd5, "b2b_wrong");
        pressDigit(4'd3, "b2b_right");
    endtask

    task automatic test_random();
        logic [3:0] d;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1 && modelLevel < 3) d = 4'(code[modelLevel]);
            else d = 4'($urandom_range(0, 15));
            pressDigit(d, "random");
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end
        applyReset();
    endtask

`ifdef CODE_PROGRAM_EN
    task automatic test_program();
        int n;
        unlock("prog_unlock");
        bus.prog = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.digit_in = 4'd9;
            bus.btn_pulse = 1'b1;
            tick();
            bus.btn_pulse = 1'b0;
            checks++;
            if (bus.enter_o !== 1'b0) $display("[TB] FAIL program write %0d enter got %b want 0", i, bus.enter_o); else passes++;
            tick();
        end
        bus.prog = 1'b0;
        code = '{9, 9, 9};
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.enter_o !== 1'b1 && n < 40);
        checks++;
        if (n != 16) $display("[TB] FAIL program relock latency got %0d want 16", n); else passes++;
        tick();
        tick();
        modelLevel = 0;
        pressDigit(4'd3, "prog_oldcode");
        pressDigit(4'd9, "prog_new0");
        pressDigit(4'd9, "prog_new1");
        pressDigit(4'd9, "prog_new2");
        applyReset();
        code = '{3, 7, 1};
    endtask
`endif

    // Scenario sequence.
    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_auto_relock();
        test_relock_collision();
        test_back_to_back();
        test_random();
`ifdef CODE_PROGRAM_EN
        test_program();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lock_entry_controller.md
Name: lock_entry_controller

Overview:
Sequencer in front of the 3-digit combination-lock Moore FSM. Converts a debounced button pulse plus digit switches into single-cycle `enter`/`correct_digit` strobes for the FSM. The FSM's state selects which code digit to compare against. Adds failed-attempt lockout and auto-relock after a timeout. Sits between the button debouncer/switch inputs and the lock FSM; reads the FSM state back.

Parameters:
DIGIT_W, 4, width of one code digit
MAX_FAILS, 3, consecutive wrong digits that trigger lockout (1..3)
LOCKOUT_CYCLES, 50000000, clk cycles buttons are ignored during lockout
RELOCK_CYCLES, 100000000, clk cycles in unlocked state before automatic relock
CODE0, 4'd3, first code digit (reset value)
CODE1, 4'd7, second code digit (reset value)
CODE2, 4'd1, third code digit (reset value)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
btn_pulse  in  1  one-cycle debounced enter press
digit_in  in  DIGIT_W  digit switches, sampled on btn_pulse
prog  in  1  code-program request (used only with CODE_PROGRAM_EN)
fsm_state  in  2  current state of lock FSM (0..2 locked progress, 3 unlocked)
enter_o  out  1  one-cycle enter strobe to FSM
correct_digit_o  out  1  compare result, valid while enter_o=1, else 0
lockout_led  out  1  high during lockout
fail_count  out  2  consecutive wrong-digit count
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; ctrl state IDLE; timer 0; code registers = CODE0..2.
- Ctrl states: IDLE, PULSE, SETTLE, LOCKOUT.
- IDLE, btn_pulse=1, fsm_state<3:
  - cmp = (digit_in == code[fsm_state]).
  - Next cycle: PULSE with enter_o=1, correct_digit_o=cmp.
- IDLE, btn_pulse=1, fsm_state==3: manual relock.
  - PULSE with correct_digit_o=0.
  - Timer cleared; fail_count unchanged.
- PULSE lasts exactly 1 cycle. Latency from btn_pulse to enter_o is 1 cycle. Then SETTLE for 1 cycle so the updated fsm_state is visible before the next press.
- Fail counting, applied on the PULSE cycle for fsm_state<3 only:
  - Wrong digit: fail_count+1.
  - Correct digit: fail_count cleared to 0.
  - If the incremented count == MAX_FAILS: go SETTLE then LOCKOUT (not IDLE).
- LOCKOUT:
  - lockout_led=1; timer counts from 0 to LOCKOUT_CYCLES-1.
  - Then fail_count=0, lockout_led=0, back to IDLE.
- Auto-relock: in IDLE with fsm_state==3, timer increments each cycle. At RELOCK_CYCLES-1, issue PULSE with correct_digit_o=0 and clear the timer. The FSM returns to 0.
- Timer is cleared whenever fsm_state!=3 and ctrl is in IDLE. A single shared timer suffices: lockout occurs only with fsm_state<3, relock only with fsm_state==3.
- btn_pulse during PULSE, SETTLE or LOCKOUT is dropped, not queued.
- btn_pulse in the same cycle as relock expiry: the button is serviced and the timer is cleared. Net effect is identical: one enter pulse with correct=0.
- An fsm_state change without an enter_o pulse (e.g. the FSM is reset externally) is tolerated. Compare index always uses the live fsm_state.
- Reset mid-operation: immediate return to reset values; any pending enter_o is lost.
- Digit compare is an unsigned equality on DIGIT_W bits.

Optional Feature:
CODE_PROGRAM_EN
- Defined, in IDLE with fsm_state==3, prog=1 and btn_pulse=1:
  - digit_in is written to code[prog_idx], and prog_idx increments 0→1→2→0.
  - No enter_o is issued; the relock timer is cleared.
  - prog_idx resets to 0 on reset and on any relock.
- Undefined: prog is ignored and code registers are constants CODE0..2.

Decomposition:
- Package lock_pkg:
  - FSM state constants S0..S3 (2-bit).
  - Controller state typedef (IDLE/PULSE/SETTLE/LOCKOUT).
  - DIGIT_W default.
- One sub-module, lock_timer: clear/enable up-counter with terminal-count compare against a runtime limit. It is shared by lockout and relock. Width = clog2 of the larger limit.

Test Plan:
(Benches use LOCKOUT_CYCLES=8, RELOCK_CYCLES=16, code 3,7,1, and a behavioural model of the lock FSM.)
- Digits 3,7,1 pressed with ≥3 idle cycles between → three enter_o pulses, each with correct_digit_o=1, each 1 cycle after its press; fsm_state reaches 3; fail_count=0.
- Press 5 at fsm_state 0, three times → correct_digit_o=0 each time; fail_count 1,2,3. After the third: lockout_led=1 for 8 cycles and a press of 3 is ignored (no enter_o). Afterwards fail_count=0.
- Unlock, then idle → exactly 16 cycles after entering IDLE with fsm_state=3: enter_o=1, correct_digit_o=0; fsm_state returns to 0.
- Unlock, then press at cycle 16 (relock expiry) → a single enter_o pulse with correct_digit_o=0, not two.
- Press on the cycle right after a press → second press dropped; busy=1 during PULSE/SETTLE.
- CODE_PROGRAM_EN: unlock, prog=1, press 9,9,9 → no enter_o; relock; then entering 9,9,9 unlocks and 3,7,1 gives correct_digit_o=0.
